u12_sink: RTL and testbench



---
 rtl/u12_pkg.sv | 20 ++
 rtl/u12_sink_fifo.sv | 74 +++++++
 rtl/u12_sink.sv | 81 ++++++++
 tb/tb_u12_sink.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/u12_pkg.sv
// Shared definitions for the U12 uniform-sample stream: float format constants
// and the helpers that validate a sample and turn it into an open-interval fixed-point value.
package u12_pkg;

    localparam logic [7:0] FP32_BIAS   = 8'd127;
    localparam int         FP32_MANT_W = 23;
    localparam int         UNIF_W      = 24;

    // A generator sample must lie in [1,2): positive sign, unbiased exponent zero.
    function automatic logic is_u12_fmt(input logic [31:0] data);
        return (data[31] == 1'b0) && (data[30:23] == FP32_BIAS);
    endfunction

    // Dropping the implicit 1.0 and appending a 1 LSB centres each code in its bin,
    // so the result is never 0 and never reaches 1.
    function automatic logic [UNIF_W-1:0] u12_to_fix(input logic [31:0] data);
        return {data[FP32_MANT_W-1:0], 1'b1};
    endfunction

endpackage

// File: rtl/u12_sink_fifo.sv
// Generic synchronous FIFO with a power-of-two depth; the head is read straight
// from registered storage so it stays stable while the consumer stalls.
module u12_sink_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/u12_sink.sv
// Consumer end of the U12 stream: validates float samples, converts good ones to
// 24-bit (0,1) fixed point through a small FIFO, and counts accepted and malformed samples.
module u12_sink
    import u12_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERR_W = 16,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [UNIF_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [CNT_W-1:0] SMP_ONE  = CNT_W'(1);

    logic             good;
    logic             accept;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

    assign good      = is_u12_fmt(in_data);
    assign in_ready  = (fifo_count != CNT_FULL);
    assign out_valid = (fifo_count != '0);
    assign accept    = in_valid && !fifo_full;

    u12_sink_fifo #(
        .WIDTH (UNIF_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept && good),
        .push_data (u12_to_fix(in_data)),
        .pop       (out_ready && !fifo_empty),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (out_data)
    );

    // Malformed samples still complete the handshake; they are only counted.
    always_comb begin
        err_cnt_d    = err_cnt_q;
        sample_cnt_d = sample_cnt_q;
        if (accept) begin
            if (good) begin
                sample_cnt_d = sample_cnt_q + SMP_ONE;
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q    <= '0;
            sample_cnt_q <= '0;
        end else begin
            err_cnt_q    <= err_cnt_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign err_cnt    = err_cnt_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_u12_sink.sv
// Bench for u12_sink: a default-width instance and a narrow-counter instance share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_u12_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready_a,  in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic [23:0] out_data_a,  out_data_b;
    logic [15:0] err_a;
    logic [31:0] samp_a;
    logic [3:0]  err_b;
    logic [3:0]  samp_b;

    int errors = 0;
    int checks = 0;

    logic [23:0] mq[$];
    int          err_m;
    int          samp_m;
    bit          fresh;

    always #5 clk = ~clk;

    u12_sink #(.DEPTH(4), .ERR_W(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
        .out_ready(out_ready), .err_cnt(err_a), .sample_cnt(samp_a)
    );

    u12_sink #(.DEPTH(4), .ERR_W(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_ready(out_ready), .err_cnt(err_b), .sample_cnt(samp_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] e_err_a, e_err_b, e_samp_a, e_samp_b;
        e_err_a  = (err_m > 65535) ? 32'd65535 : 32'(err_m);
        e_err_b  = (err_m > 15) ? 32'd15 : 32'(err_m);
        e_samp_a = 32'(samp_m);
        e_samp_b = 32'(samp_m % 16);
        chk("in_ready",    {31'd0, in_ready_a},  {31'd0, mq.size() != 4});
        chk("out_valid",   {31'd0, out_valid_a}, {31'd0, mq.size() != 0});
        chk("in_ready_s",  {31'd0, in_ready_b},  {31'd0, mq.size() != 4});
        chk("out_valid_s", {31'd0, out_valid_b}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("out_data",   {8'd0, out_data_a}, {8'd0, mq[0]});
            chk("out_data_s", {8'd0, out_data_b}, {8'd0, mq[0]});
        end else if (fresh) begin
            chk("out_data_rst", {8'd0, out_data_a}, 32'd0);
        end
        chk("err_cnt",      {16'd0, err_a}, e_err_a);
        chk("sample_cnt",   samp_a,         e_samp_a);
        chk("err_cnt_s",    {28'd0, err_b}, e_err_b);
        chk("sample_cnt_s", {28'd0, samp_b}, e_samp_b);
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic cycle(input logic v, input logic [31:0] d, input logic ordy, input logic r);
        bit acc, pop, good;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
        if (r) begin
            mq.delete();
            err_m  = 0;
            samp_m = 0;
            fresh  = 1'b1;
        end else begin
            acc  = v && (mq.size() < 4);
            pop  = ordy && (mq.size() > 0);
            good = ((d >> 23) == 32'd127);
            if (pop) void'(mq.pop_front());
            if (acc) begin
                if (good) begin
                    mq.push_back(24'(((d & 32'h007F_FFFF) * 2) + 1));
                    samp_m++;
                    fresh = 1'b0;
                end else begin
                    err_m++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    function automatic logic [31:0] rand_good();
        return {9'h07F, 23'($urandom)};
    endfunction

    typedef struct {
        logic [31:0] din;
        logic        good;
        logic [23:0] fix;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{32'h3FC0_0000, 1'b1, 24'h800001};
        vt[1] = '{32'h3F80_0000, 1'b1, 24'h000001};
        vt[2] = '{32'h3FFF_FFFF, 1'b1, 24'hFFFFFF};
        vt[3] = '{32'h3F8A_BCDE, 1'b1, 24'h1579BD};
        vt[4] = '{32'h3F80_0001, 1'b1, 24'h000003};
        vt[5] = '{32'h4000_0000, 1'b0, 24'h000000};
        vt[6] = '{32'hBFC0_0000, 1'b0, 24'h000000};
        vt[7] = '{32'h3F00_0000, 1'b0, 24'h000000};
        vt[8] = '{32'h7F80_0000, 1'b0, 24'h000000};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        mq.delete(); err_m = 0; samp_m = 0; fresh = 1'b0;
        @(negedge clk);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("rst_out_data",  {8'd0, out_data_a},   32'd0);
        chk("rst_in_ready",  {31'd0, in_ready_a},  32'd1);

        // Table: each vector into an empty FIFO, checked, then drained.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, vt[i].din, 1'b0, 1'b0);
            chk("tbl_valid", {31'd0, out_valid_a}, {31'd0, vt[i].good});
            if (vt[i].good) chk("tbl_data", {8'd0, out_data_a}, {8'd0, vt[i].fix});
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end

        // First sample after reset, one-cycle latency.
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 32'h3FC0_0000, 1'b1, 1'b0);
        chk("lat_valid", {31'd0, out_valid_a}, 32'd1);
        chk("lat_data",  {8'd0, out_data_a}, 32'h0080_0001);
        chk("lat_samp",  samp_a, 32'd1);
        chk("lat_err",   {16'd0, err_a}, 32'd0);
        cycle(1'b1, 32'h3F80_0000, 1'b1, 1'b0);
        chk("seq_data0", {8'd0, out_data_a}, 32'h0000_0001);
        cycle(1'b1, 32'h3FFF_FFFF, 1'b1, 1'b0);
        chk("seq_data1", {8'd0, out_data_a}, 32'h00FF_FFFF);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // Malformed samples are consumed and counted only.
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 32'h4000_0000, 1'b1, 1'b0);
        cycle(1'b1, 32'hBFC0_0000, 1'b1, 1'b0);
        chk("bad_err",   {16'd0, err_a}, 32'd2);
        chk("bad_samp",  samp_a, 32'd0);
        chk("bad_ready", {31'd0, in_ready_a}, 32'd1);
        chk("bad_valid", {31'd0, out_valid_a}, 32'd0);

        // Fill with a stalled consumer, then release with input held.
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, rand_good(), 1'b0, 1'b0);
        chk("full_ready", {31'd0, in_ready_a}, 32'd0);
        chk("full_samp",  samp_a, 32'd4);
        for (int i = 0; i < 8; i++) cycle(1'b1, rand_good(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // Counter saturation and wrap on the narrow instance.
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h4000_0000, 1'b1, 1'b0);
        chk("sat_err_s", {28'd0, err_b}, 32'd15);
        chk("sat_err",   {16'd0, err_a}, 32'd20);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) cycle(1'b1, rand_good(), 1'b1, 1'b0);
        chk("wrap_samp_s", {28'd0, samp_b}, 32'd1);
        chk("wrap_samp",   samp_a, 32'd17);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // Mid-stream reset with a sample in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_good(), 1'b0, 1'b0);
        cycle(1'b1, rand_good(), 1'b1, 1'b1);
        chk("mrst_valid", {31'd0, out_valid_a}, 32'd0);
        chk("mrst_data",  {8'd0, out_data_a}, 32'd0);
        chk("mrst_samp",  samp_a, 32'd0);
        chk("mrst_err",   {16'd0, err_a}, 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("mrst_after", {31'd0, out_valid_a}, 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) != 0) ? rand_good() : $urandom;
            cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
